vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator. It divides the system clock into a pixel tick and runs horizontal and vertical raster counters over a configurable mode. All sync, blanking and position outputs are registered and mutually aligned. It feeds pixel-colour and sprite-lookup logic (heart, bullets, HP bar, menus) and replaces the fixed 640x480 sync generator, adding programmable polarity, enable/freeze and line/frame markers.

## Interface
Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1)
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CW, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  run; low freezes divider, counters and outputs
- p_tick  out  1  one-clk pixel strobe
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- video_on  out  1  pixel is inside the visible area
- line_start  out  1  pixel period of h = 0
- frame_start  out  1  pixel period of (0,0)
- x  out  CW  horizontal position of the current output pixel
- y  out  CW  vertical position of the current output pixel

## Operation
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Divider div counts 0..CLK_DIV-1 and wraps while enable is high. p_tick = enable && div==0. With CLK_DIV=1, p_tick = enable.
- On each clk edge with p_tick high:
  - Output registers load the decode of the current (h,v).
  - h advances; at H_TOTAL-1 it wraps to 0 and v advances.
  - v wraps from V_TOTAL-1 to 0.
- Decode of (h,v):
  - x = h, y = v.
  - video_on = h<H_DISPLAY && v<V_DISPLAY.
  - hsync is active (= HS_POL) for H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC; otherwise ~HS_POL.
  - vsync is active (= VS_POL) for V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC; otherwise ~VS_POL.
  - vsync changes only at the line boundary.
  - line_start = h==0; frame_start = h==0 && v==0.
- enable low: div, h, v and all outputs hold their values; p_tick is 0. Operation resumes where it stopped.
- Unsigned arithmetic throughout. Comparisons use CW-bit values. No out-of-range counter states are reachable.

## Timing
- Reset values:
  - div = 0, h = 0, v = 0.
  - x = 0, y = 0, video_on = 0, line_start = 0, frame_start = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - p_tick follows enable (combinational from div).
- Reset asserted mid-frame forces all of the above immediately (asynchronous).
- After reset release with enable high, the first clk edge is a p_tick edge. Outputs then show x=0, y=0, video_on=1, line_start=1, frame_start=1.
- Latency: outputs describe the pixel that the counters held before the p_tick edge. Each value is stable for exactly CLK_DIV clocks while enabled.
- line_start and frame_start are high for one full pixel period (CLK_DIV clocks), not for a single clk.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV enabled clocks (1,680,000 at defaults).

## Structure
- Package vga_timing_pkg:
  - default mode constants (640x480@60 porch/sync values) and derived H_TOTAL/V_TOTAL functions;
  - polarity constants;
  - a clog2-based CW helper.
- Sub-module pixel_tick_div: the CLK_DIV divider with enable, producing p_tick.
- Counters and output decode/registers stay in vga_timing_gen.

## Test plan
- Defaults, enable=1, reset pulse -> frame_start rises 1 clk after release. The next frame_start comes 1,680,000 clks later; line_start every 3,200 clks.
- Defaults, one line -> hsync=0 exactly for x 656..751; video_on=1 for x 0..639 on y<480; video_on=0 for y 480..524.
- Defaults, one frame -> vsync=0 exactly for y 490..491. y wraps 524->0 coincident with x wrap 799->0.
- HS_POL=1, VS_POL=1, CLK_DIV=1, tiny mode (H 4/1/2/1, V 3/1/1/1) -> hsync=1 for x 5..6; vsync=1 for y 4; p_tick high every clk.
- Toggle enable low for 37 clks mid-line at x=100 -> x, y, hsync and video_on hold; p_tick=0; the sequence resumes at x=101 with no skipped pixel.
- Assert reset at x=700, y=300 -> all outputs take reset values in the same cycle; after release the sequence restarts at (0,0).

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Package vga_timing_pkg: shared constants and helpers for the VGA raster timing generator.
//   - default 640x480@60 mode values (porch/sync widths, pixel divider)
//   - sync polarity constants
//   - h_total/v_total mode-size functions and a clog2-based counter width helper
package vga_timing_pkg;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  function automatic int h_total(int display, int front, int sync, int back);
    return display + front + sync + back;
  endfunction

  function automatic int v_total(int display, int front, int sync, int back);
    return display + front + sync + back;
  endfunction

  // Width needed to hold values 0..max_value.
  function automatic int cw_for(int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

  localparam int DEF_CW = cw_for(h_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK) - 1);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Interface vga_timing_gen_if: raster timing bundle from the generator to pixel/sprite logic.
//   master (generator): drives p_tick, hsync, vsync, video_on, line_start, frame_start, x, y
//   slave  (consumer) : receives the same signals
interface vga_timing_gen_if #(
  parameter int CW = 10
) ();
  logic          p_tick;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          line_start;
  logic          frame_start;
  logic [CW-1:0] x;
  logic [CW-1:0] y;

  modport master (
    output p_tick, hsync, vsync, video_on, line_start, frame_start, x, y
  );

  modport slave (
    input p_tick, hsync, vsync, video_on, line_start, frame_start, x, y
  );
endinterface

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// Module pixel_tick_div: divides clk into a one-clk pixel strobe.
//   clk, reset (async, active-high), enable (low freezes the divider)
//   p_tick: high while enabled and the divider sits at 0; combinational from the divider register
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic p_tick
);
  localparam int            DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (enable) begin
      div <= (div == DIV_MAX) ? '0 : div + DW'(1);
    end
  end

  // With CLK_DIV=1 the divider never leaves 0, so p_tick simply follows enable.
  assign p_tick = enable && (div == '0);
endmodule

// File: rtl/vga_timing_gen.sv
// Module vga_timing_gen: parametrised VGA raster timing generator.
//   clk, reset (async, active-high), enable (low freezes divider, counters and outputs)
//   vga (master modport): p_tick strobe plus registered hsync/vsync/video_on/line_start/
//   frame_start/x/y, all describing the pixel the counters held before the last p_tick edge.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HS_POL    = POL_ACTIVE_LOW,
  parameter bit VS_POL    = POL_ACTIVE_LOW,
  parameter int CW        = DEF_CW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CW-1:0] H_MAX    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC);

  logic          p_tick;
  logic [CW-1:0] h;
  logic [CW-1:0] v;

  logic          video_on_d;
  logic          hs_act_d;
  logic          vs_act_d;

  logic          hsync_q;
  logic          vsync_q;
  logic          video_on_q;
  logic          line_start_q;
  logic          frame_start_q;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .p_tick (p_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (p_tick) begin
      if (h == H_MAX) begin
        h <= '0;
        v <= (v == V_MAX) ? '0 : v + CW'(1);
      end else begin
        h <= h + CW'(1);
      end
    end
  end

  // vsync decodes v only, and v moves only on the h wrap, so vsync edges land on line boundaries.
  always_comb begin
    video_on_d = (h < H_VIS) && (v < V_VIS);
    hs_act_d   = (h >= HS_START) && (h < HS_END);
    vs_act_d   = (v >= VS_START) && (v < VS_END);
  end

  // Output registers load the decode of the pre-edge (h,v), so they lag the counters by one pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else if (p_tick) begin
      hsync_q       <= hs_act_d ? HS_POL : ~HS_POL;
      vsync_q       <= vs_act_d ? VS_POL : ~VS_POL;
      video_on_q    <= video_on_d;
      line_start_q  <= (h == '0);
      frame_start_q <= (h == '0) && (v == '0);
      x_q           <= h;
      y_q           <= v;
    end
  end

  assign vga.p_tick      = p_tick;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
endmodule
